arrow_scheduler: RTL and testbench

ARROW_SCHEDULER -- requirements
Module: arrow_scheduler

---
 rtl/arrow_pkg.sv | 33 +++
 rtl/lfsr8.sv | 23 ++
 rtl/arrow_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_arrow_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arrow_pkg.sv
// Shared types, default constants and LFSR helpers for the arrow scheduler.
package arrow_pkg;

  // Scheduler FSM states.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Default geometry and timing, matching the arrow drawing block.
  localparam int DEF_CORDW        = 10;
  localparam int DEF_ARROW_COUNT  = 3;
  localparam int DEF_SCREEN_H     = 480;
  localparam int DEF_SPEED        = 2;
  localparam int DEF_SPAWN_PERIOD = 30;
  localparam int DEF_HIT_Y_MIN    = 400;
  localparam int DEF_HIT_Y_MAX    = 440;

  // LFSR defaults: taps 8,6,5,4 are bits 7,5,4,3 of the register.
  localparam logic [7:0] DEF_LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS     = 8'hB8;

  // Feedback bit shifted into bit 0 on each step.
  function automatic logic lfsr8_fb(input logic [7:0] q);
    return ^(q & LFSR_TAPS);
  endfunction

  // Next LFSR value (shift-left, feedback into the LSB).
  function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
    return {q[6:0], lfsr8_fb(q)};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR used to pick the spawn lane; advances only on step_i.
module lfsr8
  import arrow_pkg::*;
#(
  parameter logic [7:0] SEED = DEF_LFSR_SEED
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       step_i,
  output logic [7:0] q_o
);

  // Shift register: load the seed on reset, step once per request.
  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_o <= SEED;
    end else if (step_i) begin
      q_o <= lfsr8_next(q_o);
    end
  end

endmodule

// File: rtl/arrow_scheduler.sv
// Arrow scheduler: spawns arrows into lanes, moves them down once per frame,
// scores hits inside the hit window and flags arrows that fall off screen.
module arrow_scheduler
  import arrow_pkg::*;
#(
  parameter int         CORDW        = DEF_CORDW,
  parameter int         ARROW_COUNT  = DEF_ARROW_COUNT,
  parameter int         SCREEN_H     = DEF_SCREEN_H,
  parameter int         SPEED        = DEF_SPEED,
  parameter int         SPAWN_PERIOD = DEF_SPAWN_PERIOD,
  parameter int         HIT_Y_MIN    = DEF_HIT_Y_MIN,
  parameter int         HIT_Y_MAX    = DEF_HIT_Y_MAX,
  parameter logic [7:0] LFSR_SEED    = DEF_LFSR_SEED
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         stop_i,
  input  logic                         frame_i,
  input  logic [ARROW_COUNT-1:0]       hit_i,
  output logic [CORDW*ARROW_COUNT-1:0] arrow_y_o,
  output logic [ARROW_COUNT-1:0]       arrow_active_o,
  output logic                         hit_o,
  output logic                         miss_o,
  output logic [7:0]                   score_o,
  output logic                         running_o
);

  localparam int FC_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(SPAWN_PERIOD - 1);
  localparam logic [CORDW-1:0] Y_OFF   = CORDW'(SCREEN_H);
  localparam logic [CORDW-1:0] WIN_LO  = CORDW'(HIT_Y_MIN);
  localparam logic [CORDW-1:0] WIN_HI  = CORDW'(HIT_Y_MAX);
  // One extra bit so y + SPEED near the bottom edge cannot wrap.
  localparam logic [CORDW:0]   Y_LIMIT = (CORDW+1)'(SCREEN_H);
  localparam logic [CORDW:0]   Y_STEP  = (CORDW+1)'(SPEED);

  state_t                 state_q, state_d;
  logic [CORDW-1:0]       y_q [ARROW_COUNT];
  logic [CORDW-1:0]       y_d [ARROW_COUNT];
  logic [ARROW_COUNT-1:0] active_q, active_d;
  logic                   hit_q, hit_d;
  logic                   miss_q, miss_d;
  logic [7:0]             score_q, score_d;
  logic [FC_W-1:0]        frame_cnt_q, frame_cnt_d;

  logic                   go;        // IDLE -> RUN this cycle
  logic                   halt;      // RUN -> IDLE this cycle
  logic                   live;      // RUN and staying in RUN
  logic                   lfsr_step;
  logic [7:0]             lfsr_q;
  logic [1:0]             spawn_bits;
  int                     spawn_lane;
  logic [CORDW:0]         y_sum;
  logic [7:0]             hit_cnt;
  logic [8:0]             score_sum;

  lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .step_i (lfsr_step),
    .q_o    (lfsr_q)
  );

  // Low two bits of the LFSR value after the pending step pick the spawn lane.
  assign spawn_bits = {lfsr_q[0], lfsr8_fb(lfsr_q)};

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: stop has priority over start.
  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    halt    = 1'b0;
    live    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          state_d = RUN;
          go      = 1'b1;
        end
      end
      RUN: begin
        if (stop_i) begin
          state_d = IDLE;
          halt    = 1'b1;
        end else begin
          live    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lane datapath: hits on pre-move y first, then movement/misses, then spawn.
  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    y_d         = y_q;
    active_d    = active_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    score_d     = score_q;
    frame_cnt_d = frame_cnt_q;
    lfsr_step   = 1'b0;
    y_sum       = '0;
    hit_cnt     = '0;
    score_sum   = '0;
    spawn_lane  = int'(spawn_bits);
    if (spawn_lane >= ARROW_COUNT) begin
      spawn_lane = 0;
    end

    if (go) begin
      score_d     = '0;
      frame_cnt_d = '0;
    end else if (halt) begin
      active_d = '0;
      for (int i = 0; i < ARROW_COUNT; i++) begin
        y_d[i] = Y_OFF;
      end
    end else if (live) begin
      // Hits are judged on the y the arrow had before this frame's move.
      for (int i = 0; i < ARROW_COUNT; i++) begin
        if (hit_i[i] && active_q[i] && (y_q[i] >= WIN_LO) && (y_q[i] <= WIN_HI)) begin
          active_d[i] = 1'b0;
          y_d[i]      = Y_OFF;
          hit_cnt     = hit_cnt + 8'd1;
        end
      end

      if (frame_i) begin
        // Lanes just hit are already inactive, so they neither move nor miss.
        for (int i = 0; i < ARROW_COUNT; i++) begin
          if (active_d[i]) begin
            y_sum = {1'b0, y_q[i]} + Y_STEP;
            if (y_sum >= Y_LIMIT) begin
              active_d[i] = 1'b0;
              y_d[i]      = Y_OFF;
              miss_d      = 1'b1;
            end else begin
              y_d[i] = y_sum[CORDW-1:0];
            end
          end
        end

        if (frame_cnt_q == FC_LAST) begin
          frame_cnt_d = '0;
          lfsr_step   = 1'b1;
          // A lane freed earlier in this same frame may take the new arrow.
          for (int i = 0; i < ARROW_COUNT; i++) begin
            if ((i == spawn_lane) && !active_d[i]) begin
              active_d[i] = 1'b1;
              y_d[i]      = '0;
            end
          end
        end else begin
          frame_cnt_d = frame_cnt_q + FC_W'(1);
        end
      end

      hit_d     = (hit_cnt != 8'd0);
      score_sum = {1'b0, score_q} + {1'b0, hit_cnt};
      score_d   = (score_sum > 9'd255) ? 8'hFF : score_sum[7:0];
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q    <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      score_q     <= '0;
      frame_cnt_q <= '0;
      // NOTE: the lane y registers are reset, not left as plain storage, because an idle lane must drive SCREEN_H.
      for (int i = 0; i < ARROW_COUNT; i++) begin
        y_q[i] <= Y_OFF;
      end
    end else begin
      active_q    <= active_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      score_q     <= score_d;
      frame_cnt_q <= frame_cnt_d;
      for (int i = 0; i < ARROW_COUNT; i++) begin
        y_q[i] <= y_d[i];
      end
    end
  end

  // Pack lane y values for the drawing block.
  for (genvar g = 0; g < ARROW_COUNT; g++) begin : g_pack
    assign arrow_y_o[g*CORDW +: CORDW] = y_q[g];
  end

  assign arrow_active_o = active_q;
  assign hit_o          = hit_q;
  assign miss_o         = miss_q;
  assign score_o        = score_q;
  assign running_o      = (state_q == RUN);

endmodule

// File: tb/tb_arrow_scheduler.sv
// Self-checking bench for arrow_scheduler: vector table, directed corner
// sequences, and randomized traffic against a behavioural lane model.
module tb_arrow_scheduler;

  localparam int CORDW = 10;
  localparam int LANES = 3;
  localparam int H     = 480;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic        frame = 1'b0;
  logic [2:0]  hit   = 3'b000;
  logic [29:0] arrow_y;
  logic [2:0]  arrow_active;
  logic        hit_p;
  logic        miss_p;
  logic [7:0]  score;
  logic        running;

  int n_tests = 0;
  int n_fail  = 0;

  arrow_scheduler dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .stop_i         (stop),
    .frame_i        (frame),
    .hit_i          (hit),
    .arrow_y_o      (arrow_y),
    .arrow_active_o (arrow_active),
    .hit_o          (hit_p),
    .miss_o         (miss_p),
    .score_o        (score),
    .running_o      (running)
  );

  always #5 clk = ~clk;

  // Behavioural model: lane positions as plain integers.
  int m_y [LANES];
  bit m_act [LANES];
  int m_score;
  int m_fc;
  int m_lfsr;
  bit m_run;
  bit m_hit;
  bit m_miss;

  typedef struct {
    bit         start;
    bit         stop;
    bit         frame;
    logic [2:0] hit;
    bit         e_run;
    logic [2:0] e_act;
    logic [7:0] e_score;
    bit         e_hit;
    bit         e_miss;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run   = 1'b0;
    m_score = 0;
    m_fc    = 0;
    m_lfsr  = 'hA5;
    m_hit   = 1'b0;
    m_miss  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      m_act[i] = 1'b0;
      m_y[i]   = H;
    end
  endtask

  task automatic model_step(input bit s, input bit p, input bit f, input logic [2:0] h);
    int nh;
    int lane;
    m_hit  = 1'b0;
    m_miss = 1'b0;
    if (!m_run) begin
      if (s && !p) begin
        m_run   = 1'b1;
        m_score = 0;
        m_fc    = 0;
      end
    end else if (p) begin
      m_run = 1'b0;
      for (int i = 0; i < LANES; i++) begin
        m_act[i] = 1'b0;
        m_y[i]   = H;
      end
    end else begin
      nh = 0;
      for (int i = 0; i < LANES; i++) begin
        if (h[i] && m_act[i] && m_y[i] >= 400 && m_y[i] <= 440) begin
          m_act[i] = 1'b0;
          m_y[i]   = H;
          nh++;
        end
      end
      if (f) begin
        for (int i = 0; i < LANES; i++) begin
          if (m_act[i]) begin
            if (m_y[i] + 2 >= H) begin
              m_act[i] = 1'b0;
              m_y[i]   = H;
              m_miss   = 1'b1;
            end else begin
              m_y[i] = m_y[i] + 2;
            end
          end
        end
        if (m_fc == 29) begin
          m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1)) & 255;
          lane = m_lfsr % 4;
          if (lane == 3) lane = 0;
          if (!m_act[lane]) begin
            m_act[lane] = 1'b1;
            m_y[lane]   = 0;
          end
        end
        m_fc = (m_fc + 1) % 30;
      end
      m_hit   = (nh > 0);
      m_score = (m_score + nh > 255) ? 255 : m_score + nh;
    end
  endtask

  // Drive one cycle of inputs, sample #1 after the edge, advance the model.
  task automatic apply(input bit s, input bit p, input bit f, input logic [2:0] h);
    start = s;
    stop  = p;
    frame = f;
    hit   = h;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    frame = 1'b0;
    hit   = 3'b000;
    model_step(s, p, f, h);
  endtask

  task automatic frames(input int n);
    repeat (n) apply(1'b0, 1'b0, 1'b1, 3'b000);
  endtask

  task automatic hard_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic compare_model(input string tag);
    logic [29:0] ey;
    logic [2:0]  ea;
    for (int i = 0; i < LANES; i++) begin
      ey[i*CORDW +: CORDW] = 10'(m_y[i]);
      ea[i]                = m_act[i];
    end
    check({tag, ".y"},       32'(arrow_y),      32'(ey));
    check({tag, ".active"},  32'(arrow_active), 32'(ea));
    check({tag, ".hit"},     32'(hit_p),        32'(m_hit));
    check({tag, ".miss"},    32'(miss_p),       32'(m_miss));
    check({tag, ".score"},   32'(score),        32'(m_score));
    check({tag, ".running"}, 32'(running),      32'(m_run));
  endtask

  // Bound on total simulated time.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [29:0] ey;
    int          cyc;

    vecs[0] = '{1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 3'b000, 8'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 8'd0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 8'd0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 3'b000, 8'd0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 3'b111, 1'b1, 3'b000, 8'd0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000, 8'd0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 8'd0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 3'b000, 8'd0, 1'b0, 1'b0};

    // Reset state, observed while reset is held.
    #1;
    rst = 1'b1;
    #10;
    ey = {10'd480, 10'd480, 10'd480};
    check("reset.y",       32'(arrow_y),      32'(ey));
    check("reset.active",  32'(arrow_active), 32'd0);
    check("reset.running", 32'(running),      32'd0);
    check("reset.score",   32'(score),        32'd0);
    check("reset.hit",     32'(hit_p),        32'd0);
    check("reset.miss",    32'(miss_p),       32'd0);
    #1;
    rst = 1'b0;
    model_reset();

    // Control vectors: IDLE filtering, stop-over-start, start/stop.
    for (int k = 0; k < 8; k++) begin
      apply(vecs[k].start, vecs[k].stop, vecs[k].frame, vecs[k].hit);
      check($sformatf("vec%0d.running", k), 32'(running),      32'(vecs[k].e_run));
      check($sformatf("vec%0d.active", k),  32'(arrow_active), 32'(vecs[k].e_act));
      check($sformatf("vec%0d.score", k),   32'(score),        32'(vecs[k].e_score));
      check($sformatf("vec%0d.hit", k),     32'(hit_p),        32'(vecs[k].e_hit));
      check($sformatf("vec%0d.miss", k),    32'(miss_p),       32'(vecs[k].e_miss));
    end

    // First spawn lands in lane 2 on the 30th frame.
    hard_reset();
    apply(1'b1, 1'b0, 1'b0, 3'b000);
    frames(29);
    check("spawn.early_active", 32'(arrow_active), 32'd0);
    frames(1);
    check("spawn.active", 32'(arrow_active), 32'b100);
    ey = {10'd0, 10'd480, 10'd480};
    check("spawn.y", 32'(arrow_y), 32'(ey));

    // Fall to y=400 after 200 frames, then to 478, then miss.
    frames(200);
    check("fall.y400", 32'(arrow_y[29:20]), 32'd400);
    frames(39);
    check("fall.y478", 32'(arrow_y[29:20]), 32'd478);
    check("fall.no_miss_yet", 32'(miss_p), 32'd0);
    frames(1);
    check("fall.miss", 32'(miss_p), 32'd1);
    check("fall.inactive", 32'(arrow_active[2]), 32'd0);
    check("fall.y480", 32'(arrow_y[29:20]), 32'd480);

    // Hit just below the window is ignored; hit with frame at y=410 scores.
    hard_reset();
    apply(1'b1, 1'b0, 1'b0, 3'b000);
    frames(229);
    check("early_hit.y398", 32'(arrow_y[29:20]), 32'd398);
    apply(1'b0, 1'b0, 1'b0, 3'b100);
    check("early_hit.hit", 32'(hit_p), 32'd0);
    check("early_hit.active", 32'(arrow_active[2]), 32'd1);
    check("early_hit.y", 32'(arrow_y[29:20]), 32'd398);
    check("early_hit.score", 32'(score), 32'd0);
    frames(6);
    check("hit.y410", 32'(arrow_y[29:20]), 32'd410);
    apply(1'b0, 1'b0, 1'b1, 3'b100);
    check("hit.hit", 32'(hit_p), 32'd1);
    check("hit.miss", 32'(miss_p), 32'd0);
    check("hit.score", 32'(score), 32'd1);
    check("hit.active", 32'(arrow_active), 32'b011);
    ey = {10'd480, 10'd352, 10'd232};
    check("hit.y", 32'(arrow_y), 32'(ey));

    // Asynchronous reset mid-run with two lanes in flight.
    #3;
    rst = 1'b1;
    #1;
    ey = {10'd480, 10'd480, 10'd480};
    check("async_rst.active",  32'(arrow_active), 32'd0);
    check("async_rst.y",       32'(arrow_y),      32'(ey));
    check("async_rst.running", 32'(running),      32'd0);
    check("async_rst.score",   32'(score),        32'd0);
    check("async_rst.hit",     32'(hit_p),        32'd0);
    check("async_rst.miss",    32'(miss_p),       32'd0);
    #1;
    rst = 1'b0;
    model_reset();
    apply(1'b1, 1'b0, 1'b0, 3'b000);
    frames(30);
    check("restart.active", 32'(arrow_active), 32'b100);
    ey = {10'd0, 10'd480, 10'd480};
    check("restart.y", 32'(arrow_y), 32'(ey));

    // Score saturation: hit every arrow as soon as it reaches the window.
    cyc = 0;
    while (m_score < 255 && cyc < 60000) begin
      apply(1'b0, 1'b0, 1'b1, 3'b111);
      check("sat_run.score", 32'(score), 32'(m_score));
      check("sat_run.hit",   32'(hit_p), 32'(m_hit));
      cyc++;
    end
    check("sat.score255", 32'(score), 32'd255);
    cyc = 0;
    while (!m_hit && cyc < 2000) begin
      apply(1'b0, 1'b0, 1'b1, 3'b111);
      cyc++;
    end
    check("sat.hit_pulse", 32'(hit_p), 32'd1);
    check("sat.hold255",   32'(score), 32'd255);

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      logic [2:0] h;
      for (int b = 0; b < 3; b++) h[b] = ($urandom_range(0, 7) == 0);
      apply($urandom_range(0, 19) == 0, $urandom_range(0, 599) == 0,
            $urandom_range(0, 1) == 1, h);
      compare_model($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
